mc_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control unit for the MIPS core: the next generation of the current fixed-timing controller. Sequences FETCH/DECODE/EXEC/MEM/WB against variable-latency instruction and data memories using req/rdy handshakes. Drives all datapath enables and mux selects. Traps on memory timeout or illegal opcode.

---
 rtl/mc_ctrl_fsm.sv | 380 ++++++++++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control unit for the MIPS core. Sequences FETCH / DECODE / EXEC /
// MEM / WB against variable-latency instruction and data memories (req/rdy
// handshakes), drives the datapath enables and mux selects, and traps on a
// memory timeout or an unsupported instruction.
//
// Parameters:
//   MEM_TIMEOUT  max cycles a memory req may stay unacknowledged (1..65535)
//   TO_W         timeout counter width, 2**TO_W > MEM_TIMEOUT
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   op, funct                instruction[31:26] / [5:0], valid from DECODE on
//   zero, of                 ALU zero (beq) and overflow (addi) flags
//   imem_rdy, dmem_rdy       memory acknowledges
//   imem_req, dmem_req       memory requests; dmem_we / mem_size qualify dmem
//   ir_we, enpc, npc_sel     IR latch, PC strobe, next-PC source
//   gpr_we, gpr_sel, wd_sel  register file write enable / dest / data source
//   alu_op, bsel, ext_op     ALU operation, B operand source, immediate extend
//   state                    current state encoding
//   trap, trap_cause         sticky error flag, 0 = mem timeout, 1 = illegal
//
// Optional build macro PERF_CNT_EN adds cyc_cnt[31:0] (cycles outside TRAP)
// and ret_cnt[31:0] (retired instructions). Undefined: ports and logic absent.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        of,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mem_size,
  output logic        ir_we,
  output logic        enpc,
  output logic [1:0]  npc_sel,
  output logic        gpr_we,
  output logic [1:0]  gpr_sel,
  output logic [1:0]  wd_sel,
  output logic [2:0]  alu_op,
  output logic        bsel,
  output logic [1:0]  ext_op,
  output logic [2:0]  state,
  output logic        trap,
  output logic        trap_cause
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUBU   = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_ILL  = 4'd0,  C_ADDU = 4'd1,  C_SUBU = 4'd2,  C_JR  = 4'd3,
    C_J    = 4'd4,  C_JAL  = 4'd5,  C_ORI  = 4'd6,  C_ADDI = 4'd7,
    C_LW   = 4'd8,  C_LB   = 4'd9,  C_SW   = 4'd10, C_SB  = 4'd11,
    C_BEQ  = 4'd12
  } cls_t;

  state_t          state_r, state_next_s;
  cls_t            cls_s;
  logic [TO_W-1:0] to_cnt_r;
  logic            trap_r, trap_cause_r;
  logic            enter_trap_s, cause_s;
  logic            wait_s, to_last_s, is_load_s, is_store_s;
  logic            imem_req_s, dmem_req_s, dmem_we_s, mem_size_s, ir_we_s, enpc_s;
  logic            gpr_we_s, bsel_s;
  logic [1:0]      npc_sel_s, gpr_sel_s, wd_sel_s, ext_op_s;
  logic [2:0]      alu_op_s;

  // Instruction class decode from the opcode/funct fields.
  always_comb begin
    cls_s = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU:  cls_s = C_ADDU;
          F_SUBU:  cls_s = C_SUBU;
          F_JR:    cls_s = C_JR;
          default: cls_s = C_ILL;
        endcase
      end
      OP_J:    cls_s = C_J;
      OP_JAL:  cls_s = C_JAL;
      OP_BEQ:  cls_s = C_BEQ;
      OP_ADDI: cls_s = C_ADDI;
      OP_ORI:  cls_s = C_ORI;
      OP_LB:   cls_s = C_LB;
      OP_LW:   cls_s = C_LW;
      OP_SB:   cls_s = C_SB;
      OP_SW:   cls_s = C_SW;
      default: cls_s = C_ILL;
    endcase
  end

  assign is_load_s  = (cls_s == C_LW) || (cls_s == C_LB);
  assign is_store_s = (cls_s == C_SW) || (cls_s == C_SB);
  // Last permitted wait cycle: a wait here means the count reaches MEM_TIMEOUT.
  assign to_last_s  = (to_cnt_r == TO_W'(MEM_TIMEOUT - 1));
  assign wait_s     = (imem_req_s & ~imem_rdy) | (dmem_req_s & ~dmem_rdy);

  // Next-state and Moore output decode; rst forces every strobe low at once so
  // an abandoned handshake is dropped before the next clock edge.
  always_comb begin
    state_next_s = state_r;
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    mem_size_s   = 1'b0;
    ir_we_s      = 1'b0;
    enpc_s       = 1'b0;
    npc_sel_s    = 2'b00;
    gpr_we_s     = 1'b0;
    gpr_sel_s    = 2'b00;
    wd_sel_s     = 2'b00;
    alu_op_s     = 3'b000;
    bsel_s       = 1'b0;
    ext_op_s     = 2'b00;
    enter_trap_s = 1'b0;
    cause_s      = 1'b0;
    if (rst) begin
      state_next_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          imem_req_s = 1'b1;
          if (imem_rdy) begin
            ir_we_s      = 1'b1;
            enpc_s       = 1'b1;
            state_next_s = S_DECODE;
          end else if (to_last_s) begin
            enter_trap_s = 1'b1;
            state_next_s = S_TRAP;
          end else begin
            state_next_s = S_FETCH;
          end
        end
        S_DECODE: begin
          case (cls_s)
            C_J: begin
              enpc_s       = 1'b1;
              npc_sel_s    = 2'b10;
              state_next_s = S_FETCH;
            end
            C_JAL: begin
              enpc_s       = 1'b1;
              npc_sel_s    = 2'b10;
              gpr_we_s     = 1'b1;
              gpr_sel_s    = 2'b10;
              wd_sel_s     = 2'b10;
              state_next_s = S_FETCH;
            end
            C_JR: begin
              enpc_s       = 1'b1;
              npc_sel_s    = 2'b11;
              state_next_s = S_FETCH;
            end
            C_ILL: begin
              enter_trap_s = 1'b1;
              cause_s      = 1'b1;
              state_next_s = S_TRAP;
            end
            default: state_next_s = S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls_s)
            C_ADDU: begin
              alu_op_s     = 3'b000;
              state_next_s = S_WB;
            end
            C_SUBU: begin
              alu_op_s     = 3'b001;
              state_next_s = S_WB;
            end
            C_ORI: begin
              alu_op_s     = 3'b010;
              bsel_s       = 1'b1;
              ext_op_s     = 2'b00;
              state_next_s = S_WB;
            end
            C_ADDI: begin
              bsel_s       = 1'b1;
              ext_op_s     = 2'b01;
              state_next_s = S_WB;
            end
            C_LW, C_LB, C_SW, C_SB: begin
              bsel_s       = 1'b1;
              ext_op_s     = 2'b01;
              state_next_s = S_MEM;
            end
            C_BEQ: begin
              alu_op_s = 3'b001;
              if (zero) begin
                enpc_s    = 1'b1;
                npc_sel_s = 2'b01;
              end else begin
                enpc_s    = 1'b0;
                npc_sel_s = 2'b00;
              end
              state_next_s = S_FETCH;
            end
            default: begin
              // op changed under us after DECODE; treat as illegal
              enter_trap_s = 1'b1;
              cause_s      = 1'b1;
              state_next_s = S_TRAP;
            end
          endcase
        end
        S_MEM: begin
          if (is_load_s || is_store_s) begin
            dmem_req_s = 1'b1;
            dmem_we_s  = is_store_s;
            mem_size_s = (cls_s == C_LB) || (cls_s == C_SB);
            // rdy on the final permitted cycle wins over the timeout
            if (dmem_rdy) begin
              if (is_store_s) begin
                state_next_s = S_FETCH;
              end else begin
                state_next_s = S_WB;
              end
            end else if (to_last_s) begin
              enter_trap_s = 1'b1;
              state_next_s = S_TRAP;
            end else begin
              state_next_s = S_MEM;
            end
          end else begin
            enter_trap_s = 1'b1;
            cause_s      = 1'b1;
            state_next_s = S_TRAP;
          end
        end
        S_WB: begin
          state_next_s = S_FETCH;
          case (cls_s)
            C_ADDU, C_SUBU: begin
              gpr_we_s  = 1'b1;
              gpr_sel_s = 2'b01;
            end
            C_ORI: gpr_we_s = 1'b1;
            // addi overflow suppresses the write (flag held from EXEC)
            C_ADDI: gpr_we_s = ~of;
            C_LW, C_LB: begin
              gpr_we_s = 1'b1;
              wd_sel_s = 2'b01;
            end
            default: begin
              enter_trap_s = 1'b1;
              cause_s      = 1'b1;
              state_next_s = S_TRAP;
            end
          endcase
        end
        S_TRAP: state_next_s = S_TRAP;
        default: begin
          enter_trap_s = 1'b1;
          state_next_s = S_TRAP;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake timeout counter; any state change restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_next_s != state_r) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (wait_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Sticky trap flag and cause, captured on entry to TRAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_r       <= 1'b0;
      trap_cause_r <= 1'b0;
    end else if (enter_trap_s) begin
      trap_r       <= 1'b1;
      trap_cause_r <= cause_s;
    end else begin
      trap_r       <= trap_r;
      trap_cause_r <= trap_cause_r;
    end
  end

`ifdef PERF_CNT_EN
  logic        retire_s;
  logic [31:0] cyc_cnt_r, ret_cnt_r;

  // An instruction retires when its final state hands back to FETCH.
  assign retire_s = (state_next_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_TRAP);

  // Free-running cycle and retire counters, wrapping at 2**32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_r <= 32'd0;
      ret_cnt_r <= 32'd0;
    end else begin
      if (state_r != S_TRAP) begin
        cyc_cnt_r <= cyc_cnt_r + 32'd1;
      end else begin
        cyc_cnt_r <= cyc_cnt_r;
      end
      if (retire_s) begin
        ret_cnt_r <= ret_cnt_r + 32'd1;
      end else begin
        ret_cnt_r <= ret_cnt_r;
      end
    end
  end

  assign cyc_cnt = cyc_cnt_r;
  assign ret_cnt = ret_cnt_r;
`endif

  assign imem_req   = imem_req_s;
  assign dmem_req   = dmem_req_s;
  assign dmem_we    = dmem_we_s;
  assign mem_size   = mem_size_s;
  assign ir_we      = ir_we_s;
  assign enpc       = enpc_s;
  assign npc_sel    = npc_sel_s;
  assign gpr_we     = gpr_we_s;
  assign gpr_sel    = gpr_sel_s;
  assign wd_sel     = wd_sel_s;
  assign alu_op     = alu_op_s;
  assign bsel       = bsel_s;
  assign ext_op     = ext_op_s;
  assign state      = state_r;
  assign trap       = trap_r;
  assign trap_cause = trap_cause_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm (MEM_TIMEOUT=4, TO_W=3). A table of per-cycle
// {inputs, expected outputs} records walks every supported instruction; short
// hand-written sequences cover cycle counts, timeouts, illegal instructions and
// asynchronous reset in the middle of a data handshake.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_NONE  = 6'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic       zero = 1'b0, of = 1'b0, imem_rdy = 1'b0, dmem_rdy = 1'b0;
  logic       imem_req, dmem_req, dmem_we, mem_size, ir_we, enpc, gpr_we, bsel;
  logic       trap, trap_cause;
  logic [1:0] npc_sel, gpr_sel, wd_sel, ext_op;
  logic [2:0] alu_op, state;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .of(of),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_size(mem_size), .ir_we(ir_we),
    .enpc(enpc), .npc_sel(npc_sel), .gpr_we(gpr_we), .gpr_sel(gpr_sel),
    .wd_sel(wd_sel), .alu_op(alu_op), .bsel(bsel), .ext_op(ext_op),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req, dmem_req, dmem_we, mem_size, ir_we, enpc;
    logic [1:0] npc_sel;
    logic       gpr_we;
    logic [1:0] gpr_sel, wd_sel;
    logic [2:0] alu_op;
    logic       bsel;
    logic [1:0] ext_op;
    logic       trap, trap_cause;
  } exp_t;

  typedef struct {
    string      name;
    logic [5:0] op, funct;
    logic       zero, of, irdy, drdy;
    exp_t       exp;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected-output builders: everything zero except the named fields.
  function automatic exp_t ex(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic exp_t ef(input logic rdy);
    exp_t e;
    e = ex(3'd0);
    e.imem_req = 1'b1; e.ir_we = rdy; e.enpc = rdy;
    return e;
  endfunction

  function automatic exp_t ed(input logic en, input logic [1:0] npc, input logic we,
                              input logic [1:0] gs, input logic [1:0] wd);
    exp_t e;
    e = ex(3'd1);
    e.enpc = en; e.npc_sel = npc; e.gpr_we = we; e.gpr_sel = gs; e.wd_sel = wd;
    return e;
  endfunction

  function automatic exp_t ee(input logic [2:0] alu, input logic bs, input logic [1:0] ext,
                              input logic en, input logic [1:0] npc);
    exp_t e;
    e = ex(3'd2);
    e.alu_op = alu; e.bsel = bs; e.ext_op = ext; e.enpc = en; e.npc_sel = npc;
    return e;
  endfunction

  function automatic exp_t em(input logic we, input logic sz);
    exp_t e;
    e = ex(3'd3);
    e.dmem_req = 1'b1; e.dmem_we = we; e.mem_size = sz;
    return e;
  endfunction

  function automatic exp_t ew(input logic we, input logic [1:0] gs, input logic [1:0] wd);
    exp_t e;
    e = ex(3'd4);
    e.gpr_we = we; e.gpr_sel = gs; e.wd_sel = wd;
    return e;
  endfunction

  function automatic exp_t et(input logic cause);
    exp_t e;
    e = ex(3'd7);
    e.trap = 1'b1; e.trap_cause = cause;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.state = state; a.imem_req = imem_req; a.dmem_req = dmem_req;
    a.dmem_we = dmem_we; a.mem_size = mem_size; a.ir_we = ir_we; a.enpc = enpc;
    a.npc_sel = npc_sel; a.gpr_we = gpr_we; a.gpr_sel = gpr_sel; a.wd_sel = wd_sel;
    a.alu_op = alu_op; a.bsel = bsel; a.ext_op = ext_op; a.trap = trap;
    a.trap_cause = trap_cause;
    return a;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t a;
    a = actual();
    n_checks++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, a, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle by +2.
  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic ov, input logic ir, input logic dr);
    @(negedge clk);
    op = o; funct = f; zero = z; of = ov; imem_rdy = ir; dmem_rdy = dr;
    #2;
  endtask

  task automatic add(input string name, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic ov, input logic ir, input logic dr,
                     input exp_t e);
    vec_t v;
    v.name = name; v.op = o; v.funct = f; v.zero = z; v.of = ov;
    v.irdy = ir; v.drdy = dr; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    op = 6'h00; funct = 6'h00; zero = 1'b0; of = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
    #2;
    check("reset_state", ex(3'd0));
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one instruction with zero wait states from FETCH and counts cycles
  // until the FSM is back in FETCH (bounded).
  task automatic run_count(input string name, input logic [5:0] o, input logic [5:0] f,
                           input int exp_cyc);
    int cyc;
    @(negedge clk);
    op = o; funct = f; zero = 1'b0; of = 1'b0; imem_rdy = 1'b1; dmem_rdy = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (state != 3'd0 && cyc < 20);
    n_checks++;
    if (cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s: got %0d cycles required %0d", name, cyc, exp_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- table: one record per clock cycle ----------------
    add("addu_f", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("addu_d", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("addu_e", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b000, 1'b0, 2'b00, 1'b0, 2'b00));
    add("addu_w", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ew(1'b1, 2'b01, 2'b00));
    add("subu_f", OP_R, F_SUBU, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("subu_d", OP_R, F_SUBU, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("subu_e", OP_R, F_SUBU, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b001, 1'b0, 2'b00, 1'b0, 2'b00));
    add("subu_w", OP_R, F_SUBU, 1'b0, 1'b0, 1'b1, 1'b1, ew(1'b1, 2'b01, 2'b00));
    add("ori_f", OP_ORI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("ori_d", OP_ORI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("ori_e", OP_ORI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b010, 1'b1, 2'b00, 1'b0, 2'b00));
    add("ori_w", OP_ORI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ew(1'b1, 2'b00, 2'b00));
    add("addi_f", OP_ADDI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("addi_d", OP_ADDI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("addi_e", OP_ADDI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    add("addi_w", OP_ADDI, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ew(1'b1, 2'b00, 2'b00));
    add("addiov_f", OP_ADDI, F_NONE, 1'b0, 1'b1, 1'b1, 1'b1, ef(1'b1));
    add("addiov_d", OP_ADDI, F_NONE, 1'b0, 1'b1, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("addiov_e", OP_ADDI, F_NONE, 1'b0, 1'b1, 1'b1, 1'b1, ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    add("addiov_w", OP_ADDI, F_NONE, 1'b0, 1'b1, 1'b1, 1'b1, ew(1'b0, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++)
      add("lw_fwait", OP_LW, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0, ef(1'b0));
    add("lw_f", OP_LW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0, ef(1'b1));
    add("lw_d", OP_LW, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("lw_e", OP_LW, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0, ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    for (int i = 0; i < 2; i++)
      add("lw_mwait", OP_LW, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0, em(1'b0, 1'b0));
    add("lw_m", OP_LW, F_NONE, 1'b0, 1'b0, 1'b0, 1'b1, em(1'b0, 1'b0));
    add("lw_w", OP_LW, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0, ew(1'b1, 2'b00, 2'b01));
    add("lb_f", OP_LB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("lb_d", OP_LB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("lb_e", OP_LB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    add("lb_m", OP_LB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, em(1'b0, 1'b1));
    add("lb_w", OP_LB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ew(1'b1, 2'b00, 2'b01));
    add("sb_f", OP_SB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("sb_d", OP_SB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("sb_e", OP_SB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    add("sb_m", OP_SB, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, em(1'b1, 1'b1));
    add("beqt_f", OP_BEQ, F_NONE, 1'b1, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("beqt_d", OP_BEQ, F_NONE, 1'b1, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("beqt_e", OP_BEQ, F_NONE, 1'b1, 1'b0, 1'b1, 1'b1, ee(3'b001, 1'b0, 2'b00, 1'b1, 2'b01));
    add("beqn_f", OP_BEQ, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("beqn_d", OP_BEQ, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("beqn_e", OP_BEQ, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b001, 1'b0, 2'b00, 1'b0, 2'b00));
    add("j_f", OP_J, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("j_d", OP_J, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b1, 2'b10, 1'b0, 2'b00, 2'b00));
    add("jal_f", OP_JAL, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("jal_d", OP_JAL, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b1, 2'b10, 1'b1, 2'b10, 2'b10));
    add("jr_f", OP_R, F_JR, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("jr_d", OP_R, F_JR, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b1, 2'b11, 1'b0, 2'b00, 2'b00));
    add("sw_f", OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0, ef(1'b1));
    add("sw_d", OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("sw_e", OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0, ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    for (int i = 0; i < 3; i++)
      add("sw_mwait", OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0, em(1'b1, 1'b0));
    add("sw_m_rdy4", OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1, em(1'b1, 1'b0));
    add("post_sw_f", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ef(1'b1));
    add("post_sw_d", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    add("post_sw_e", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ee(3'b000, 1'b0, 2'b00, 1'b0, 2'b00));
    add("post_sw_w", OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1, ew(1'b1, 2'b01, 2'b00));

    repeat (2) @(posedge clk);
    #1 check("reset_state", ex(3'd0));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].op, vq[i].funct, vq[i].zero, vq[i].of, vq[i].irdy, vq[i].drdy);
      check(vq[i].name, vq[i].exp);
    end

    // ---------------- zero-wait-state cycle counts ----------------
    run_count("cyc_addu", OP_R, F_ADDU, 4);
    run_count("cyc_ori", OP_ORI, F_NONE, 4);
    run_count("cyc_sw", OP_SW, F_NONE, 4);
    run_count("cyc_lw", OP_LW, F_NONE, 5);
    run_count("cyc_beq", OP_BEQ, F_NONE, 3);
    run_count("cyc_j", OP_J, F_NONE, 2);
    run_count("cyc_jal", OP_JAL, F_NONE, 2);
    run_count("cyc_jr", OP_R, F_JR, 2);

    // ---------------- data timeout: 4 unacknowledged req cycles ----------------
    drive(OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0); check("to_sw_f", ef(1'b1));
    drive(OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0); check("to_sw_d", ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    drive(OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0); check("to_sw_e", ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    for (int i = 0; i < 4; i++) begin
      drive(OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
      check("to_sw_mwait", em(1'b1, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      drive(OP_SW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
      check("to_sw_trap", et(1'b0));
    end

    // ---------------- instruction fetch timeout ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(OP_R, F_ADDU, 1'b0, 1'b0, 1'b0, 1'b0);
      check("to_if_wait", ef(1'b0));
    end
    drive(OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1); check("to_if_trap", et(1'b0));

    // ---------------- illegal opcode / funct ----------------
    do_reset();
    drive(6'h3F, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1); check("ill_op_f", ef(1'b1));
    drive(6'h3F, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1); check("ill_op_d", ex(3'd1));
    drive(6'h3F, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1); check("ill_op_trap", et(1'b1));
    drive(OP_R, F_ADDU, 1'b0, 1'b0, 1'b1, 1'b1); check("ill_op_stay", et(1'b1));
    do_reset();
    drive(OP_R, 6'h20, 1'b0, 1'b0, 1'b1, 1'b1); check("ill_fn_f", ef(1'b1));
    drive(OP_R, 6'h20, 1'b0, 1'b0, 1'b1, 1'b1); check("ill_fn_d", ex(3'd1));
    drive(OP_R, 6'h20, 1'b0, 1'b0, 1'b1, 1'b1); check("ill_fn_trap", et(1'b1));

    // ---------------- async reset mid data handshake ----------------
    do_reset();
    drive(OP_LW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0); check("ar_f", ef(1'b1));
    drive(OP_LW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0); check("ar_d", ed(1'b0, 2'b00, 1'b0, 2'b00, 2'b00));
    drive(OP_LW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0); check("ar_e", ee(3'b000, 1'b1, 2'b01, 1'b0, 2'b00));
    drive(OP_LW, F_NONE, 1'b0, 1'b0, 1'b1, 1'b0); check("ar_m", em(1'b0, 1'b0));
    #1 rst = 1'b1;
    #1 check("ar_async", ex(3'd0));
    @(posedge clk);
    #1 rst = 1'b0;
    run_count("ar_recover_addu", OP_R, F_ADDU, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
